// File: rtl/cp0_nest_irq_if.sv
// Pipeline <-> CP0 bus: interrupt handshake, exception entry, ERET, mtc0/mfc0 and PC redirect.
interface cp0_nest_irq_if #(
   parameter int unsigned IRQ_N = 4
);
   logic [IRQ_N-1:0] irq;
   logic             int_req;
   logic             int_ack;
   logic             exc_req;
   logic [4:0]       exc_code;
   logic [31:0]      pc;
   logic [31:0]      npc;
   logic             eret;
   logic             mtc0;
   logic [4:0]       c0_addr;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic [3:0]       nest_lvl;

   modport master (
      output irq, int_ack, exc_req, exc_code, pc, npc, eret, mtc0, c0_addr, wdata,
      input  int_req, rdata, redirect, redirect_pc, nest_lvl
   );

   modport slave (
      input  irq, int_ack, exc_req, exc_code, pc, npc, eret, mtc0, c0_addr, wdata,
      output int_req, rdata, redirect, redirect_pc, nest_lvl
   );
endinterface

// File: rtl/cp0_nest_irq.sv
// Coprocessor 0 with synchronised external IRQs, Count/Compare timer and a
// hardware Status stack for nested exception entry / ERET.
module cp0_nest_irq #(
   parameter int unsigned IRQ_N      = 4,
   parameter int unsigned NEST_DEPTH = 3,
   parameter logic [31:0] EXC_VEC    = 32'h0000_0004
) (
   input logic            clk,
   input logic            rst,
   cp0_nest_irq_if.slave  bus
);
   localparam int unsigned TM_BIT    = 8 + IRQ_N;
   localparam logic [4:0]  A_COUNT   = 5'd9;
   localparam logic [4:0]  A_COMPARE = 5'd11;
   localparam logic [4:0]  A_STATUS  = 5'd12;
   localparam logic [4:0]  A_CAUSE   = 5'd13;
   localparam logic [4:0]  A_EPC     = 5'd14;

   logic [IRQ_N-1:0] irq_meta_p0;
   logic [IRQ_N-1:0] irq_sync_p1;
   logic [IRQ_N-1:0] ip_q;
   logic [31:0]      status_q;
   logic [31:0]      epc_q;
   logic [31:0]      count_q;
   logic [31:0]      compare_q;
   logic [4:0]       exc_code_q;
   logic             tp_q;
   logic             ovf_q;
   logic [3:0]       nest_lvl_q;
   logic [7:0]       stack_q [NEST_DEPTH];

   logic        int_req;
   logic        take_exc;
   logic        take_int;
   logic        entry;
   logic        do_eret;
   logic        at_full;
   logic [7:0]  stack_top;
   logic [31:0] rdata_mux;

   function automatic logic [31:0] cause_word(input logic [4:0] code, input logic [IRQ_N-1:0] ip,
                                              input logic tp, input logic ovf);
      cause_word            = '0;
      cause_word[6:2]       = code;
      cause_word[8 +: IRQ_N] = ip;
      cause_word[TM_BIT]    = tp;
      cause_word[31]        = ovf;
   endfunction

   always_comb begin
      int_req  = status_q[0]
               & ((|(ip_q & status_q[8 +: IRQ_N])) | (tp_q & status_q[TM_BIT]))
               & (nest_lvl_q < 4'(NEST_DEPTH));
      // A synchronous exception always beats a pending interrupt acknowledge.
      take_exc = bus.exc_req;
      take_int = bus.int_ack & int_req & ~bus.exc_req;
      entry    = take_exc | take_int;
      do_eret  = bus.eret & ~entry;
      at_full  = (nest_lvl_q == 4'(NEST_DEPTH));
   end

   always_comb begin
      stack_top = '0;
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
         if (nest_lvl_q == 4'(i + 1)) stack_top = stack_q[i];
      end
   end

   always_comb begin
      rdata_mux = '0;
      if (rst) begin
         case (bus.c0_addr)
            A_COUNT:   rdata_mux = count_q;
            A_COMPARE: rdata_mux = compare_q;
            A_STATUS:  rdata_mux = status_q;
            A_CAUSE:   rdata_mux = cause_word(exc_code_q, ip_q, tp_q, ovf_q);
            A_EPC:     rdata_mux = epc_q;
            default:   rdata_mux = '0;
         endcase
      end
   end

   assign bus.int_req     = int_req;
   assign bus.rdata       = rdata_mux;
   assign bus.redirect    = rst & (entry | bus.eret);
   assign bus.redirect_pc = !rst    ? 32'd0 :
                            entry    ? EXC_VEC :
                            bus.eret ? epc_q : 32'd0;
   assign bus.nest_lvl    = nest_lvl_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         irq_meta_p0 <= '0;
         irq_sync_p1 <= '0;
         ip_q        <= '0;
         status_q    <= '0;
         epc_q       <= '0;
         count_q     <= '0;
         compare_q   <= '0;
         exc_code_q  <= '0;
         tp_q        <= 1'b0;
         ovf_q       <= 1'b0;
         nest_lvl_q  <= '0;
         for (int i = 0; i < int'(NEST_DEPTH); i++) stack_q[i] <= '0;
      end else begin
         // irq -> meta -> sync -> IP: three edges from pin to pending bit
         irq_meta_p0 <= bus.irq;
         irq_sync_p1 <= irq_meta_p0;
         ip_q        <= irq_sync_p1;

         count_q <= (bus.mtc0 && bus.c0_addr == A_COUNT) ? bus.wdata : count_q + 32'd1;
         if (bus.mtc0 && bus.c0_addr == A_COMPARE) begin
            compare_q <= bus.wdata;
            tp_q      <= 1'b0;
         end else if (count_q == compare_q && compare_q != 32'd0) begin
            tp_q <= 1'b1;
         end

         if (entry) begin
            epc_q       <= take_exc ? bus.pc : bus.npc;
            exc_code_q  <= take_exc ? bus.exc_code : 5'd0;
            status_q[0] <= 1'b0;
            // Only an exception can arrive at full depth; int_req is masked there.
            if (at_full) begin
               ovf_q <= 1'b1;
            end else begin
               for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                  if (nest_lvl_q == 4'(i)) stack_q[i] <= status_q[7:0];
               end
               nest_lvl_q <= nest_lvl_q + 4'd1;
            end
         end else if (do_eret) begin
            if (nest_lvl_q != 4'd0) begin
               status_q[7:0] <= stack_top;
               nest_lvl_q    <= nest_lvl_q - 4'd1;
            end else begin
               status_q[0] <= 1'b1;
            end
         end else if (bus.mtc0) begin
            case (bus.c0_addr)
               A_STATUS: status_q <= bus.wdata;
               A_CAUSE: begin
                  exc_code_q <= bus.wdata[6:2];
                  if (!bus.wdata[31]) ovf_q <= 1'b0;
               end
               A_EPC:    epc_q <= bus.wdata;
               default:  ;
            endcase
         end
      end
   end
endmodule
